// File: rtl/fetch_decode_stage_register.sv
// IF/ID pipeline register between fetch and decode.
// Uses a valid/ready handshake and a synchronous flush that squashes all held entries.
// An optional second (skid) entry lets in_ready be driven from a flop.
// Whenever out_valid is low the outputs carry a NOP bubble, so decode can use the word unqualified.
module fetch_decode_stage_register #(
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     PC_WIDTH    = 64,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'hD503201F,
    parameter int                     SKID        = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]    pc_out
);

    localparam bit USE_SKID = (SKID != 0);

    logic                   skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;

    logic can_load;
    logic accept;
    logic consume;

    // The main register can take new data when it is empty or is being drained this cycle.
    assign can_load = !out_valid || out_ready;
    assign consume  = out_valid && out_ready;
    assign accept   = in_valid && in_ready;

    // With a skid entry, in_ready depends only on the skid flop, so there is no path from out_ready.
    // Without a skid entry, in_ready passes backpressure straight through.
    assign in_ready = USE_SKID ? !skid_valid : can_load;

    // Main register. Flush has top priority, then the skid drains ahead of new input (FIFO order).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid       <= 1'b0;
            instruction_out <= NOP_INSTR;
            pc_out          <= '0;
        end else if (flush) begin
            out_valid       <= 1'b0;
            instruction_out <= NOP_INSTR;
        end else if (skid_valid && can_load) begin
            out_valid       <= 1'b1;
            instruction_out <= skid_instr;
            pc_out          <= skid_pc;
        end else if (accept && can_load) begin
            out_valid       <= 1'b1;
            instruction_out <= instruction_in;
            pc_out          <= pc_in;
        end else if (consume) begin
            // Drained with nothing to replace it: present a bubble; pc_out keeps its last value.
            out_valid       <= 1'b0;
            instruction_out <= NOP_INSTR;
        end
    end

    // Skid entry: catches an accepted word while the main register is stalled, and empties into main.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && can_load) begin
            skid_valid <= 1'b0;
        end else if (USE_SKID && accept && !can_load) begin
            skid_valid <= 1'b1;
            skid_instr <= instruction_in;
            skid_pc    <= pc_in;
        end
    end

endmodule
